vga_sync_gen: RTL

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/pix_edge_det.sv | 24 ++
 rtl/vga_sync_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, counter width and a window-compare
// helper shared by the VGA sync generator.
package vga_timing_pkg;

   localparam int CNT_W         = 10;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;
   localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   function automatic logic in_window(input logic [CNT_W-1:0] val, input int lo, input int hi);
      return (int'(val) >= lo) && (int'(val) <= hi);
   endfunction

endpackage

// File: rtl/pix_edge_det.sv
// Rising-edge detector for the pixel-rate enable, sampled as data in clk_in.
module pix_edge_det (
   input  logic clk_in,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic din_d;
   logic din_q;

   always_comb begin
      din_d = din;
   end

   // Resetting high means a level already high at release is not an edge.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) din_q <= 1'b1;
      else       din_q <= din_d;
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical sync generator advancing once per pix_clk rising edge.
// Optional frame_start output is built when VGA_FRAME_PULSE_EN is defined.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_VISIBLE   = H_VISIBLE_DEF,
   parameter int   H_FRONT     = H_FRONT_DEF,
   parameter int   H_SYNC      = H_SYNC_DEF,
   parameter int   H_BACK      = H_BACK_DEF,
   parameter int   V_VISIBLE   = V_VISIBLE_DEF,
   parameter int   V_FRONT     = V_FRONT_DEF,
   parameter int   V_SYNC      = V_SYNC_DEF,
   parameter int   V_BACK      = V_BACK_DEF,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             pix_clk,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
`ifdef VGA_FRAME_PULSE_EN
   output logic             frame_start,
`endif
   output logic             pix_tick
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_LO   = H_VISIBLE + H_FRONT;
   localparam int HS_HI   = H_VISIBLE + H_FRONT + H_SYNC - 1;
   localparam int VS_LO   = V_VISIBLE + V_FRONT;
   localparam int VS_HI   = V_VISIBLE + V_FRONT + V_SYNC - 1;
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   logic             rise;
   logic [CNT_W-1:0] h_cnt_d, h_cnt_q;
   logic [CNT_W-1:0] v_cnt_d, v_cnt_q;
   logic             hsync_d, hsync_q;
   logic             vsync_d, vsync_q;
   logic             video_on_d, video_on_q;
   logic             tick_d, tick_q;
   logic             frame_d, frame_q;

   pix_edge_det u_edge (
      .clk_in (clk_in),
      .reset  (reset),
      .din    (pix_clk),
      .rise   (rise)
   );

   // Decodes are taken from the next counts so they land in the same register
   // stage as the counters and never lag them by a pixel.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      tick_d  = rise;
      if (rise) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) v_cnt_d = '0;
            else                   v_cnt_d = v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
      hsync_d    = in_window(h_cnt_d, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d    = in_window(v_cnt_d, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_d = (int'(h_cnt_d) < H_VISIBLE) && (int'(v_cnt_d) < V_VISIBLE);
      frame_d    = rise && (h_cnt_d == '0) && (v_cnt_d == '0);
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         hsync_q    <= ~SYNC_ACTIVE;
         vsync_q    <= ~SYNC_ACTIVE;
         video_on_q <= 1'b1;
         tick_q     <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
         tick_q     <= tick_d;
         frame_q    <= frame_d;
      end
   end

   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = video_on_q;
   assign pixel_x  = h_cnt_q;
   assign pixel_y  = v_cnt_q;
   assign pix_tick = tick_q;

`ifdef VGA_FRAME_PULSE_EN
   assign frame_start = frame_q;
`else
   logic unused_frame;
   assign unused_frame = frame_q;
`endif

endmodule
